input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL be clocked by one clock, `clk`; all state is updated on its rising edge.
REQ-002 The reset `reset` SHALL be asynchronous and active-high.
REQ-003 Parameter DB_CYCLES, default 1000000: number of consecutive stable cycles needed to accept a button level change (20 ms at 50 MHz).
REQ-004 Parameter CNT_W, default 20: width of the debounce counter; 2^CNT_W SHALL be >= DB_CYCLES.
REQ-005 Port `clk`, input, 1 bit: system clock.
REQ-006 Port `reset`, input, 1 bit: asynchronous active-high reset.
REQ-007 Port `btn_raw`, input, 1 bit: asynchronous, bouncing start push-button.
REQ-008 Port `sw_raw`, input, 8 bits: asynchronous operand switches.
REQ-009 Port `ready`, input, 1 bit: downstream zero-counter is idle and can accept a start.
REQ-010 Port `start_pulse`, output, 1 bit: one-cycle start request to the downstream counter.
REQ-011 Port `a_out`, output, 8 bits: operand captured with the last issued start_pulse.
REQ-012 Port `btn_db`, output, 1 bit: debounced button level.

Function
REQ-013 `btn_raw` and every `sw_raw` bit SHALL each pass through a two-flop synchronizer (sync1, sync2) before any use.
REQ-014 The FSM SHALL have four states: IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE.
- IDLE: sync2 = 1 -> WAIT_PRESS with count = 0.
- WAIT_PRESS: sync2 = 0 -> IDLE with count cleared; count = DB_CYCLES-1 and sync2 = 1 -> PRESSED; otherwise count++.
- PRESSED: sync2 = 0 -> WAIT_RELEASE with count = 0.
- WAIT_RELEASE: sync2 = 1 -> PRESSED with count cleared; count = DB_CYCLES-1 and sync2 = 0 -> IDLE; otherwise count++.
REQ-015 `btn_db` SHALL be 1 exactly while the state is PRESSED or WAIT_RELEASE.
REQ-016 When WAIT_PRESS transitions to PRESSED with ready = 1, `start_pulse` SHALL be 1 for exactly that first PRESSED cycle, and `a_out` SHALL load sync2 of the switches on the same edge.
REQ-017 When WAIT_PRESS transitions to PRESSED with ready = 0, there SHALL be no pulse and no capture; the press is consumed, and no retry occurs while the button is held.
REQ-018 Latency: with btn_raw stable high from clock edge 0, start_pulse SHALL be high in the cycle following edge DB_CYCLES+2.
REQ-019 Re-entry from WAIT_RELEASE back to PRESSED (release bounce) SHALL NOT generate a start_pulse.
REQ-020 At most one start_pulse SHALL be issued per debounced press, whatever the hold duration.
REQ-021 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-022 `a_out` SHALL hold its value between captures, independent of later switch changes.

Reset
REQ-023 Asynchronous reset SHALL force:
- state to IDLE and count to 0;
- sync flops to 0;
- start_pulse, btn_db and a_out to 0.
REQ-024 Reset asserted mid-debounce or during PRESSED SHALL abort without any pulse; after release, a still-held button SHALL need a full DB_CYCLES debounce again.

Structure
REQ-025 A shared package SHALL hold the state encoding (2 bits: IDLE=0, WAIT_PRESS=1, PRESSED=2, WAIT_RELEASE=3) and the DB_CYCLES/CNT_W defaults.
REQ-026 The two-flop synchronizer SHALL be one sub-module, `sync2`, parameterised by width and instantiated for the button (width 1) and the switches (width 8).
REQ-027 The FSM, counter, and capture register SHALL reside in input_conditioner.

Verification (DB_CYCLES=4, CNT_W=3)
REQ-028 sw_raw=8'hA5, ready=1, btn_raw high from edge 0 -> start_pulse high only after edge 6; a_out=8'hA5; btn_db=1.
REQ-029 btn_raw high for 3 cycles, then low -> no start_pulse; btn_db stays 0; state returns to IDLE.
REQ-030 Button held 50 cycles, then a release bounce (low 2 cycles, high 1, then low) -> exactly one start_pulse; btn_db returns to 0 four cycles after the stable low is synchronized.
REQ-031 ready=0 during a valid press with sw=8'h0F, previous a_out=8'hA5 -> no pulse; a_out stays 8'hA5.
REQ-032 reset pulsed at debounce count 2 -> outputs 0 immediately (asynchronously); with the button still held, the pulse comes 6 cycles after reset release, not earlier.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - state encoding and default debounce sizing
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   // 20 ms at 50 MHz
   localparam int DB_CYCLES_DEF = 1000000;
   localparam int CNT_W_DEF     = 20;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous inputs
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         q     <= '0;
      end else begin
         sync1 <= d;
         q     <= sync1;
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced start button with operand capture
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic [7:0] sw_raw,
   input  logic       ready,
   output logic       start_pulse,
   output logic [7:0] a_out,
   output logic       btn_db
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             btn_s;
   logic [7:0]       sw_s;
   state_t           state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic             pulse_next;

   sync2 #(.WIDTH(1)) u_btn_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_raw),
      .q     (btn_s)
   );

   sync2 #(.WIDTH(8)) u_sw_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw_raw),
      .q     (sw_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         start_pulse <= 1'b0;
         a_out       <= '0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         start_pulse <= pulse_next;
         if (pulse_next) begin
            a_out <= sw_s;
         end
      end
   end

   // Only the debounced press edge can request a start; a press seen while
   // not ready is consumed and never retried.
   always_comb begin
      state_next = state;
      count_next = count;
      pulse_next = 1'b0;
      unique case (state)
         IDLE: begin
            count_next = '0;
            if (btn_s) state_next = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            if (!btn_s) begin
               state_next = IDLE;
               count_next = '0;
            end else if (count == CNT_LAST) begin
               state_next = PRESSED;
               count_next = '0;
               pulse_next = ready;
            end else begin
               count_next = count + CNT_W'(1);
            end
         end
         PRESSED: begin
            count_next = '0;
            if (!btn_s) state_next = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (btn_s) begin
               state_next = PRESSED;
               count_next = '0;
            end else if (count == CNT_LAST) begin
               state_next = IDLE;
               count_next = '0;
            end else begin
               count_next = count + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase
   end

   assign btn_db = (state == PRESSED) || (state == WAIT_RELEASE);

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_raw = 1'b0;
   logic [7:0] sw_raw = 8'h00;
   logic       ready = 1'b0;
   logic       start_pulse;
   logic [7:0] a_out;
   logic       btn_db;

   int errors = 0;
   int checks = 0;
   int pulse_cnt = 0;
   int base;

   always #5 clk = ~clk;

   input_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .sw_raw      (sw_raw),
      .ready       (ready),
      .start_pulse (start_pulse),
      .a_out       (a_out),
      .btn_db      (btn_db)
   );

   always @(negedge clk) if (start_pulse) pulse_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // reset state
      tick(2);
      check("rst_pulse", 32'(start_pulse), 0);
      check("rst_btn_db", 32'(btn_db), 0);
      check("rst_a_out", 32'(a_out), 0);
      check("rst_state", 32'(dut.state), 0);

      // press with ready: pulse exactly after edge 6
      base = pulse_cnt;
      reset = 1'b0; btn_raw = 1'b1; sw_raw = 8'hA5; ready = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         check($sformatf("lat_pulse_e%0d", e), 32'(start_pulse), (e == 6) ? 1 : 0);
      end
      check("lat_a_out", 32'(a_out), 32'hA5);
      check("lat_btn_db", 32'(btn_db), 1);

      // hold to 50 cycles, then release bounce: low 2, high 1, low
      tick(42);
      btn_raw = 1'b0;
      tick(2);
      btn_raw = 1'b1;
      tick();
      btn_raw = 1'b0;
      tick(2);
      check("bounce_reenter", 32'(dut.state), 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("bounce_db_hold%0d", i), 32'(btn_db), 1);
      end
      tick();
      check("bounce_db_low", 32'(btn_db), 0);
      check("bounce_idle", 32'(dut.state), 0);
      check("bounce_one_pulse", 32'(pulse_cnt - base), 1);

      // short glitch: 3 cycles high never debounces
      base = pulse_cnt;
      btn_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("glitch_db%0d", i), 32'(btn_db), 0);
      end
      btn_raw = 1'b0;
      tick(10);
      check("glitch_db_end", 32'(btn_db), 0);
      check("glitch_idle", 32'(dut.state), 0);
      check("glitch_no_pulse", 32'(pulse_cnt - base), 0);

      // press while not ready is consumed, no retry while held
      base = pulse_cnt;
      ready = 1'b0; sw_raw = 8'h0F; btn_raw = 1'b1;
      tick(20);
      check("nrdy_btn_db", 32'(btn_db), 1);
      check("nrdy_a_out", 32'(a_out), 32'hA5);
      ready = 1'b1;
      tick(10);
      check("nrdy_no_retry", 32'(pulse_cnt - base), 0);
      check("nrdy_a_hold", 32'(a_out), 32'hA5);
      btn_raw = 1'b0;
      tick(12);
      check("nrdy_idle", 32'(dut.state), 0);

      // reset at debounce count 2, button still held
      base = pulse_cnt;
      sw_raw = 8'h3C; btn_raw = 1'b1;
      tick(5);
      check("mid_count2", 32'(dut.count), 2);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_pulse", 32'(start_pulse), 0);
      check("mid_rst_btn_db", 32'(btn_db), 0);
      check("mid_rst_a_out", 32'(a_out), 0);
      check("mid_rst_state", 32'(dut.state), 0);
      tick(2);
      reset = 1'b0;
      for (int e = 0; e < 8; e++) begin
         tick();
         check($sformatf("rel_pulse_e%0d", e), 32'(start_pulse), (e == 6) ? 1 : 0);
      end
      check("rel_a_out", 32'(a_out), 32'h3C);

      // a_out holds across later switch changes
      sw_raw = 8'hFF;
      tick(10);
      check("hold_a_out", 32'(a_out), 32'h3C);
      check("rel_one_pulse", 32'(pulse_cnt - base), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
